// File: rtl/pipeline_control_unit.sv
// Hazard, stall and flush controller for the 5-stage RV32 pipeline.
// Adds a stall watchdog and a bank of saturating performance counters.
module pipeline_control_unit #(
    parameter int NUM_STALL_SRC  = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int STALL_TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic [REG_ADDR_WIDTH-1:0] rdM,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic                      regWriteM,
    input  logic                      regWriteW,
    input  logic                      memReadE,
    input  logic                      pcsrcE,
    input  logic                      retireW,
    input  logic [NUM_STALL_SRC-1:0]  stallReq,
    input  logic [2:0]                perfSel,
    input  logic                      perfClear,
    output logic [1:0]                forwardAE,
    output logic [1:0]                forwardBE,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      stallM,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      flushW,
    output logic                      frozen,
    output logic                      hung,
    output logic [CNT_WIDTH-1:0]      perfData
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FROZEN = 2'd1,
        HUNG   = 2'd2
    } wdState_t;

    localparam int FCW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(STALL_TIMEOUT - 1);
    localparam int NUM_CNT = 6;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic freeze;
    logic loadUse;
    logic loadUseStall;
    logic branchFlush;
    logic hangEvent;

    wdState_t       state;
    wdState_t       stateNext;
    logic [FCW-1:0] frozenCnt;
    logic [FCW-1:0] frozenCntNext;

    logic [CNT_WIDTH-1:0] perfCnt [NUM_CNT];
    logic [NUM_CNT-1:0]   perfInc;
    logic [CNT_WIDTH-1:0] perfMux;

    assign freeze  = |stallReq;
    assign loadUse = memReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    // M stage wins over W; x0 is hard-wired zero and never forwarded.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (regWriteM && (rdM != '0) && (rdM == rs1E))      forwardAE = 2'b10;
        else if (regWriteW && (rdW != '0) && (rdW == rs1E)) forwardAE = 2'b01;
        if (regWriteM && (rdM != '0) && (rdM == rs2E))      forwardBE = 2'b10;
        else if (regWriteW && (rdW != '0) && (rdW == rs2E)) forwardBE = 2'b01;
    end

    // Freeze holds everything and lets a bubble drain into WB; branch beats load-use.
    always_comb begin
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushW       = 1'b0;
        loadUseStall = 1'b0;
        branchFlush  = 1'b0;
        if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pcsrcE) begin
            flushD      = 1'b1;
            flushE      = 1'b1;
            branchFlush = 1'b1;
        end else if (loadUse) begin
            stallF       = 1'b1;
            stallD       = 1'b1;
            flushE       = 1'b1;
            loadUseStall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            frozenCnt <= '0;
        end else begin
            state     <= stateNext;
            frozenCnt <= frozenCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        frozenCntNext = frozenCnt;
        hangEvent     = 1'b0;
        unique case (state)
            RUN: begin
                if (freeze) begin
                    stateNext     = FROZEN;
                    frozenCntNext = FCW'(1);
                end
            end
            FROZEN: begin
                if (!freeze) begin
                    stateNext     = RUN;
                    frozenCntNext = '0;
                end else if (frozenCnt == FC_LAST) begin
                    stateNext = HUNG;
                    hangEvent = 1'b1;
                end else begin
                    frozenCntNext = frozenCnt + FCW'(1);
                end
            end
            HUNG:    stateNext = HUNG;
            default: stateNext = RUN;
        endcase
    end

    assign frozen = (state != RUN);
    assign hung   = (state == HUNG);

    assign perfInc = {hangEvent, retireW & ~freeze, branchFlush, loadUseStall, freeze, 1'b1};

    // Clear dominates a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rst || perfClear) begin
                perfCnt[i] <= '0;
            end else if (perfInc[i] && (perfCnt[i] != CNT_MAX)) begin
                perfCnt[i] <= perfCnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        perfMux = '0;
        case (perfSel)
            3'd0:    perfMux = perfCnt[0];
            3'd1:    perfMux = perfCnt[1];
            3'd2:    perfMux = perfCnt[2];
            3'd3:    perfMux = perfCnt[3];
            3'd4:    perfMux = perfCnt[4];
            3'd5:    perfMux = perfCnt[5];
            default: perfMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) perfData <= '0;
        else     perfData <= perfMux;
    end
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized and directed bench for pipeline_control_unit against a
// cycle-level behavioural model (run-length watchdog, integer counters).
module tb_pipeline_control_unit;
    localparam int NSRC = 2;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int TMO  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic regWriteM, regWriteW, memReadE, pcsrcE, retireW, perfClear;
    logic [NSRC-1:0] stallReq;
    logic [2:0] perfSel;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, frozen, hung;
    logic [CW-1:0] perfData;

    int nChecks = 0;
    int nFails  = 0;

    // behavioural model state
    int runLen = 0;
    bit mHung  = 0;
    int mCnt [6];
    logic [CW-1:0] expQ [$];

    pipeline_control_unit #(
        .NUM_STALL_SRC (NSRC),
        .REG_ADDR_WIDTH(RW),
        .CNT_WIDTH     (CW),
        .STALL_TIMEOUT (TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memReadE(memReadE), .pcsrcE(pcsrcE), .retireW(retireW),
        .stallReq(stallReq), .perfSel(perfSel), .perfClear(perfClear),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .frozen(frozen), .hung(hung), .perfData(perfData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [RW-1:0] rs);
        if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    function automatic logic [6:0] ctlRef();
        bit fz = |stallReq;
        bit lu = memReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        if (fz)     return 7'b1111_001;
        if (pcsrcE) return 7'b0000_110;
        if (lu)     return 7'b1100_010;
        return 7'b0000_000;
    endfunction

    task automatic idle();
        rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regWriteM = 0; regWriteW = 0; memReadE = 0; pcsrcE = 0; retireW = 0;
        stallReq = 0; perfSel = 0; perfClear = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        bit fz, lu, hangEv;
        int inc [6];
        #1;
        fz = |stallReq;
        lu = memReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        check("forwardAE", 32'(forwardAE), 32'(fwdRef(rs1E)));
        check("forwardBE", 32'(forwardBE), 32'(fwdRef(rs2E)));
        check("stallFlush", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW}), 32'(ctlRef()));
        if (rst || perfSel > 3'd5) expQ.push_back('0);
        else expQ.push_back(CW'(mCnt[perfSel]));
        @(posedge clk);
        #1;
        if (rst) begin
            runLen = 0;
            mHung  = 0;
            foreach (mCnt[i]) mCnt[i] = 0;
        end else begin
            hangEv = 0;
            if (!mHung) begin
                if (fz) begin
                    runLen++;
                    if (runLen == TMO) begin
                        mHung  = 1;
                        hangEv = 1;
                    end
                end else begin
                    runLen = 0;
                end
            end
            inc[0] = 1;
            inc[1] = int'(fz);
            inc[2] = int'(!fz && !pcsrcE && lu);
            inc[3] = int'(!fz && pcsrcE);
            inc[4] = int'(retireW && !fz);
            inc[5] = int'(hangEv);
            foreach (mCnt[i]) begin
                if (perfClear) mCnt[i] = 0;
                else if (mCnt[i] + inc[i] > CMAX) mCnt[i] = CMAX;
                else mCnt[i] = mCnt[i] + inc[i];
            end
        end
        check("frozen", 32'(frozen), 32'(mHung || runLen > 0));
        check("hung", 32'(hung), 32'(mHung));
        check("perfData", 32'(perfData), 32'(expQ.pop_front()));
        @(negedge clk);
    endtask

    task automatic doReset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic clearCounters();
        idle();
        perfClear = 1;
        cycle();
        perfClear = 0;
    endtask

    // Reads counter sel; the value reported is the count before this edge.
    task automatic readCounter(input logic [2:0] sel, input int exp, input string tag);
        idle();
        perfSel = sel;
        cycle();
        check(tag, 32'(perfData), 32'(exp));
    endtask

    initial begin
        foreach (mCnt[i]) mCnt[i] = 0;
        idle();
        rst = 1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;
        check("rstPerfData", 32'(perfData), 32'd0);
        check("rstHung", 32'(hung), 32'd0);
        check("rstFrozen", 32'(frozen), 32'd0);

        // forwarding priority and x0
        idle();
        rdM = 5; rdW = 5; rs1E = 5; regWriteM = 1; regWriteW = 1;
        #1 check("fwdM", 32'(forwardAE), 32'd2);
        cycle();
        regWriteM = 0;
        #1 check("fwdW", 32'(forwardAE), 32'd1);
        cycle();
        regWriteM = 1; rs1E = 0; rdM = 0; rdW = 0;
        #1 check("fwdX0", 32'(forwardAE), 32'd0);
        cycle();

        // load-use stall
        clearCounters();
        idle();
        memReadE = 1; rdE = 3; rs2D = 3;
        #1 check("luStall", 32'({stallF, stallD, flushE, stallE}), 32'b1110);
        cycle();
        idle();
        perfSel = 2;
        #1 check("luRelease", 32'({stallF, stallD, flushE}), 32'd0);
        cycle();
        check("luCount", 32'(perfData), 32'd1);

        // branch beats load-use
        clearCounters();
        idle();
        memReadE = 1; rdE = 3; rs2D = 3; pcsrcE = 1;
        #1 check("brFlush", 32'({flushD, flushE, stallF}), 32'b110);
        cycle();
        readCounter(3'd3, 1, "brFlushCount");
        readCounter(3'd2, 0, "brLuCount");

        // cache freeze with a pending branch
        clearCounters();
        idle();
        stallReq = 2'b01; pcsrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("frzCtl", 32'({stallF, stallD, stallE, stallM, flushW, flushD, flushE}), 32'b1111100);
            cycle();
        end
        stallReq = 2'b00;
        #1 check("frzRelease", 32'({flushD, flushE, stallF}), 32'b110);
        cycle();
        readCounter(3'd1, 4, "freezeCycles");

        // freeze ending one edge short of the timeout never hangs
        doReset();
        stallReq = 2'b10;
        for (int i = 0; i < TMO - 1; i++) cycle();
        stallReq = 2'b00;
        cycle();
        check("noHangBoundary", 32'(hung), 32'd0);

        // watchdog
        doReset();
        clearCounters();
        idle();
        stallReq = 2'b10;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i == TMO - 2) check("hungEarly", 32'(hung), 32'd0);
            if (i == TMO - 1) check("hungRise", 32'(hung), 32'd1);
        end
        readCounter(3'd5, 1, "hangEvents");
        check("hungSticky", 32'(hung), 32'd1);
        check("frozenHung", 32'(frozen), 32'd1);
        doReset();
        check("hungCleared", 32'(hung), 32'd0);

        // perfClear in the same edge as the hang
        idle();
        stallReq = 2'b01;
        for (int i = 0; i < TMO - 1; i++) cycle();
        perfClear = 1;
        cycle();
        check("clrHangHung", 32'(hung), 32'd1);
        readCounter(3'd5, 0, "clrHangEvents");

        // reset mid-freeze
        doReset();
        stallReq = 2'b01; rst = 1;
        cycle();
        check("rstMidFrz", 32'(frozen), 32'd0);
        rst = 0;
        cycle();
        check("refreeze", 32'(frozen), 32'd1);

        // saturation and clear
        doReset();
        for (int i = 0; i < 20; i++) cycle();
        readCounter(3'd0, CMAX, "cyclesSat");
        clearCounters();
        readCounter(3'd0, 0, "cyclesClr");
        readCounter(3'd6, 0, "sel6");

        // randomized traffic
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rs1D      = RW'($urandom_range(0, 3));
            rs2D      = RW'($urandom_range(0, 3));
            rs1E      = RW'($urandom_range(0, 3));
            rs2E      = RW'($urandom_range(0, 3));
            rdE       = RW'($urandom_range(0, 3));
            rdM       = RW'($urandom_range(0, 3));
            rdW       = RW'($urandom_range(0, 3));
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            memReadE  = 1'($urandom_range(0, 1));
            pcsrcE    = ($urandom_range(0, 3) == 0);
            retireW   = 1'($urandom_range(0, 1));
            perfSel   = 3'($urandom_range(0, 7));
            perfClear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) stallReq = NSRC'($urandom_range(0, 3));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
